// File: rtl/larpix_uart_pkg.sv
// Shared types and line-level constants for the UART receive path.
package larpix_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous reset.
module sync2_ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_packet.sv
// Oversampling UART receiver: one WIDTH-bit word (payload + odd parity) per frame,
// registered payload with one-cycle flag / error pulses.
module uart_rx_packet
  import larpix_uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned OVERSAMPLE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_in,
  output logic [WIDTH-2:0] rx_data,
  output logic             rx_data_flag,
  output logic             parity_error,
  output logic             framing_error,
  output logic             rx_busy
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam int unsigned OCW = $clog2(OVERSAMPLE);
  localparam logic [OCW-1:0] OS_MID   = OCW'(OVERSAMPLE / 2 - 1);
  localparam logic [OCW-1:0] OS_LAST  = OCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  logic rx_s;

  uart_rx_state_t   state_q, state_d;
  logic [OCW-1:0]   os_cnt_q, os_cnt_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-2:0] rx_data_q, rx_data_d;
  logic             flag_q, flag_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  sync2_ff #(
    .RESET_VAL(IDLE_LEVEL)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (rx_in),
    .q      (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    flag_d    = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (rx_s == START_LEVEL) begin
          state_d   = START;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end
      end
      START: begin
        if (os_cnt_q == OS_MID) begin
          os_cnt_d = '0;
          if (rx_s == IDLE_LEVEL) begin
            // Line came back high before mid-bit: treat as a glitch, not a frame.
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d  = '0;
          shift_d   = {rx_s, shift_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d = '0;
          state_d  = IDLE;
          busy_d   = 1'b0;
          // Framing takes precedence so the two error pulses never coincide.
          if (rx_s != IDLE_LEVEL) begin
            ferr_d = 1'b1;
          end else if ((^shift_q) != PARITY_ODD) begin
            perr_d = 1'b1;
          end else begin
            rx_data_d = shift_q[WIDTH-2:0];
            flag_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      flag_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      flag_q    <= flag_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_data_flag  = flag_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Directed bench for uart_rx_packet with WIDTH=64, OVERSAMPLE=4.
module tb_uart_rx_packet;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned OS    = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_in = 1'b1;
  logic [62:0] rx_data;
  logic        rx_data_flag;
  logic        parity_error;
  logic        framing_error;
  logic        rx_busy;

  uart_rx_packet #(
    .WIDTH     (WIDTH),
    .OVERSAMPLE(OS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_data_flag (rx_data_flag),
    .parity_error (parity_error),
    .framing_error(framing_error),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int          flag_cnt    = 0;
  int          perr_cnt    = 0;
  int          ferr_cnt    = 0;
  int          overlap_cnt = 0;
  int          long_cnt    = 0;
  int          busy_total  = 0;
  int          flag_cyc[16];
  logic [62:0] flag_dat[16];
  logic        prev_flag = 1'b0;
  logic        prev_perr = 1'b0;
  logic        prev_ferr = 1'b0;

  always @(negedge clk) begin
    if (rx_data_flag) begin
      if (flag_cnt < 16) begin
        flag_cyc[flag_cnt] = cyc;
        flag_dat[flag_cnt] = rx_data;
      end
      flag_cnt++;
    end
    if (parity_error) perr_cnt++;
    if (framing_error) ferr_cnt++;
    if ((rx_data_flag && parity_error) || (rx_data_flag && framing_error) ||
        (parity_error && framing_error)) overlap_cnt++;
    if ((rx_data_flag && prev_flag) || (parity_error && prev_perr) ||
        (framing_error && prev_ferr)) long_cnt++;
    if (rx_busy) busy_total++;
    prev_flag = rx_data_flag;
    prev_perr = parity_error;
    prev_ferr = framing_error;
  end

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [62:0] p, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 63; i++) send_bit(p[i]);
    send_bit(par);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int bt0;

  initial begin
    // Reset state
    idle(3);
    check("rst_rx_data", 64'(rx_data), 64'h0);
    check("rst_flag", 64'(rx_data_flag), 64'h0);
    check("rst_perr", 64'(parity_error), 64'h0);
    check("rst_ferr", 64'(framing_error), 64'h0);
    check("rst_busy", 64'(rx_busy), 64'h0);
    reset_n = 1'b1;
    idle(4);

    // 1. Good word, payload 1, parity bit 0
    send_frame(63'h1, 1'b0, 1'b1);
    idle(8);
    check("t1_flag_cnt", 64'(flag_cnt), 64'd1);
    check("t1_flag_data", 64'(flag_dat[0]), 64'h1);
    check("t1_rx_data", 64'(rx_data), 64'h1);
    check("t1_perr_cnt", 64'(perr_cnt), 64'd0);
    check("t1_ferr_cnt", 64'(ferr_cnt), 64'd0);
    check("t1_busy_low", 64'(rx_busy), 64'h0);

    // 2. Parity bit flipped
    send_frame(63'h1, 1'b1, 1'b1);
    idle(8);
    check("t2_perr_cnt", 64'(perr_cnt), 64'd1);
    check("t2_flag_cnt", 64'(flag_cnt), 64'd1);
    check("t2_rx_data", 64'(rx_data), 64'h1);
    check("t2_ferr_cnt", 64'(ferr_cnt), 64'd0);

    // 3. Stop bit low, then a good word immediately after (payload 3, parity 1)
    send_frame(63'h1, 1'b0, 1'b0);
    send_frame(63'h3, 1'b1, 1'b1);
    idle(8);
    check("t3_ferr_cnt", 64'(ferr_cnt), 64'd1);
    check("t3_perr_cnt", 64'(perr_cnt), 64'd1);
    check("t3_flag_cnt", 64'(flag_cnt), 64'd2);
    check("t3_flag_data", 64'(flag_dat[1]), 64'h3);

    // 4. One-clock glitch while idle
    bt0 = busy_total;
    rx_in = 1'b0;
    idle(1);
    rx_in = 1'b1;
    idle(12);
    check("t4_busy_cycles", 64'(busy_total - bt0), 64'd2);
    check("t4_flag_cnt", 64'(flag_cnt), 64'd2);
    check("t4_perr_cnt", 64'(perr_cnt), 64'd1);
    check("t4_ferr_cnt", 64'(ferr_cnt), 64'd1);
    check("t4_busy_low", 64'(rx_busy), 64'h0);

    // 5. Back-to-back good words
    send_frame(63'h5A5A_5A5A_5A5A_5A5A, 1'b1, 1'b1);
    send_frame(63'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    idle(8);
    check("t5_flag_cnt", 64'(flag_cnt), 64'd4);
    check("t5_data0", 64'(flag_dat[2]), 64'h5A5A_5A5A_5A5A_5A5A);
    check("t5_data1", 64'(flag_dat[3]), 64'h7FFF_FFFF_FFFF_FFFF);
    check("t5_spacing", 64'(flag_cyc[3] - flag_cyc[2]), 64'((WIDTH + 2) * OS));

    // 6. Reset pulse mid data bits; the remaining line bits are all high
    fork
      send_frame(63'h7FFF_FFFF_FFFF_FFE0, 1'b1, 1'b1);
      begin
        repeat (OS * 12) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_rx_data", 64'(rx_data), 64'h0);
        check("t6_rst_flag", 64'(rx_data_flag), 64'h0);
        check("t6_rst_busy", 64'(rx_busy), 64'h0);
        check("t6_rst_perr", 64'(parity_error), 64'h0);
        check("t6_rst_ferr", 64'(framing_error), 64'h0);
        reset_n = 1'b1;
      end
    join
    idle(8);
    check("t6_no_flag", 64'(flag_cnt), 64'd4);
    check("t6_no_err", 64'(perr_cnt + ferr_cnt), 64'd2);
    send_frame(63'h2, 1'b0, 1'b1);
    idle(8);
    check("t6_flag_cnt", 64'(flag_cnt), 64'd5);
    check("t6_flag_data", 64'(flag_dat[4]), 64'h2);

    // Pulse shape over the whole run
    check("overlap", 64'(overlap_cnt), 64'd0);
    check("pulse_width", 64'(long_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
